alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Upstream front-end for the 4-bit lab ALU.
- Turns one "enter" push-button and one "clear" push-button plus slide switches into a staged entry sequence: operand A, then operand B, then opcode.
- Holds the three values stable on registered outputs that drive the ALU's A, B and switch inputs directly.
- Exposes stage LEDs and a valid flag so the board shows the current entry step.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button level is accepted. 20 ms at 50 MHz; benches override it to 4.
- DATA_W, 4: operand width. Fixed at 4 for the current board; the parameter exists only for package consistency.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_n  in  1  raw "enter" button, active-low, asynchronous to clk
- key_clr_n  in  1  raw "clear" button, active-low, asynchronous to clk
- sw_data  in  DATA_W  slide switches supplying A or B
- sw_op  in  3  slide switches supplying the opcode
- A  out  DATA_W  registered operand A to ALU
- B  out  DATA_W  registered operand B to ALU
- switch  out  3  registered opcode to ALU
- valid  out  1  high while all three values are committed (SHOW state)
- led_stage  out  4  one-hot stage indicator; bit0=S_A, bit1=S_B, bit2=S_OP, bit3=S_SHOW

Behaviour:
- Reset (rst_n low, asynchronous):
  - A=0, B=0, switch=0, valid=0, led_stage=4'b0001, state=S_A.
  - Synchroniser flops and debounced levels = 1 (released); debounce counters = 0; press pulses = 0.
  - Reset mid-entry discards partial entry.
- Button path (per button):
  - Two-flop synchroniser.
  - Debounce counter clears on any cycle where synced level == debounced level.
  - While they differ, the counter increments. On the edge where the counter already holds DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
  - Registered press pulse: exactly one cycle, on the debounced 1->0 transition only. Release produces no pulse; holding produces one pulse.
- Latency: with edge 0 the first edge sampling key_n=0, debounced falls at edge DEBOUNCE_CYCLES+1, the pulse is high after edge DEBOUNCE_CYCLES+2, and the FSM updates at edge DEBOUNCE_CYCLES+3.
- FSM (acts on enter pulse):
  - S_A: A<=sw_data; go to S_B.
  - S_B: B<=sw_data; go to S_OP.
  - S_OP: switch<=sw_op; go to S_SHOW; valid<=1.
  - S_SHOW: go to S_A; valid<=0; A/B/switch retained until overwritten.
- Clear pulse: from any state, A=B=switch=0, valid=0, state=S_A.
  - Clear has priority over an enter pulse in the same cycle; that enter pulse is dropped.
- sw_data/sw_op are sampled directly on the latching edge without synchronisation. They are static user switches; changes between presses have no effect on outputs.
- Outputs change only on the latching edge. A, B and switch never glitch between latches.
- led_stage is decoded registered from state and is always one-hot.
- Opcode values pass through unchanged, 0..7 inclusive; no range check is applied.

Decomposition:
- Shared package alu_lab_pkg holds:
  - DATA_W = 4 and OP_W = 3.
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_GT=6, OP_EQ=7.
  - State encoding: S_A=0, S_B=1, S_OP=2, S_SHOW=3.
- One sub-module, key_debounce: synchroniser + debounce counter + press pulse, parameterised by DEBOUNCE_CYCLES.
  - Instantiated twice, once for key_n and once for key_clr_n.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst_n=0 mid-sequence with A=5 loaded -> A=0, B=0, switch=0, valid=0, led_stage=0001 immediately. No pulse after release even if key_n was held low through reset.
- Full entry:
  - sw_data=3, press -> A=3 at edge 7 after press, led_stage=0010.
  - sw_data=9, press -> B=9, led_stage=0100.
  - sw_op=1, press -> switch=1, valid=1, led_stage=1000.
  - Press again -> valid=0, led_stage=0001, A=3/B=9/switch=1 still held.
- Bounce: key_n low 3 cycles, high 2, low 3, high -> no state change. Then key_n low for 10 cycles -> exactly one advance.
- Long hold: key_n low 200 cycles in S_A -> exactly one advance to S_B. Release -> no further advance.
- Clear priority: in S_OP, key_n and key_clr_n fall on the same edge and both are held 10 cycles -> state=S_A, A=B=switch=0, valid=0, no opcode latched.
- Switch change between presses: in S_B with A=7, toggle sw_data 0..15 without pressing -> A stays 7, B stays at its previous value, no output change.

Source files
------------

// File: rtl/alu_lab_pkg.sv
// Shared types and constants for the 4-bit lab ALU and its operand-entry front-end.
package alu_lab_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT = 3'd2;
  localparam logic [OP_W-1:0] OP_AND = 3'd3;
  localparam logic [OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_GT  = 3'd6;
  localparam logic [OP_W-1:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } stage_e;

  // One-hot LED pattern for a stage; bit index equals the state encoding.
  function automatic logic [3:0] stage_led(input stage_e s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle registered pulse on each accepted press (debounced 1->0).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int unsigned    CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      deb_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= key_n_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      deb_prev_q <= deb_q;
      press_q    <= deb_prev_q & ~deb_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Staged operand entry for the lab ALU: enter steps A -> B -> opcode -> show,
// clear returns to A with all values zeroed. All outputs are registered.
module alu_operand_sequencer
  import alu_lab_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DATA_W          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
  input  logic              key_clr_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [OP_W-1:0]   sw_op,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   switch,
  output logic              valid,
  output logic [3:0]        led_stage
);

  logic enter_press, clr_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_n),
    .press_o (enter_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_clr_n),
    .press_o (clr_press)
  );

  stage_e            state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic              valid_q;
  logic [3:0]        led_q;

  // Switches are static user inputs, so they are latched directly without synchronisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      led_q   <= stage_led(S_A);
    end else if (clr_press) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      led_q   <= stage_led(S_A);
    end else if (enter_press) begin
      unique case (state_q)
        S_A: begin
          a_q     <= sw_data;
          state_q <= S_B;
          led_q   <= stage_led(S_B);
        end
        S_B: begin
          b_q     <= sw_data;
          state_q <= S_OP;
          led_q   <= stage_led(S_OP);
        end
        S_OP: begin
          op_q    <= sw_op;
          valid_q <= 1'b1;
          state_q <= S_SHOW;
          led_q   <= stage_led(S_SHOW);
        end
        S_SHOW: begin
          valid_q <= 1'b0;
          state_q <= S_A;
          led_q   <= stage_led(S_A);
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign switch    = op_q;
  assign valid     = valid_q;
  assign led_stage = led_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with a short debounce window;
// a stage-counter model tracks accepted presses and predicts every output.
module tb_alu_operand_sequencer;

  localparam int unsigned DEB    = 4;
  localparam int          SETTLE = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic [3:0] sw_data = '0;
  logic [2:0] sw_op = '0;
  logic [3:0] A, B;
  logic [2:0] switch;
  logic       valid;
  logic [3:0] led_stage;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stage index 0..3 plus the values the board should display.
  int         m_stage;
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  logic       m_valid;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .key_clr_n (key_clr_n),
    .sw_data   (sw_data),
    .sw_op     (sw_op),
    .A         (A),
    .B         (B),
    .switch    (switch),
    .valid     (valid),
    .led_stage (led_stage)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] exp_led;
    exp_led = 4'd0;
    exp_led[m_stage] = 1'b1;
    check({tag, "/A"},      32'(A),         32'(m_a));
    check({tag, "/B"},      32'(B),         32'(m_b));
    check({tag, "/switch"}, 32'(switch),    32'(m_op));
    check({tag, "/valid"},  32'(valid),     32'(m_valid));
    check({tag, "/led"},    32'(led_stage), 32'(exp_led));
  endtask

  function automatic void model_clear();
    m_stage = 0;
    m_a     = '0;
    m_b     = '0;
    m_op    = '0;
    m_valid = 1'b0;
  endfunction

  function automatic void model_enter();
    case (m_stage)
      0: m_a = sw_data;
      1: m_b = sw_data;
      2: begin m_op = sw_op; m_valid = 1'b1; end
      default: m_valid = 1'b0;
    endcase
    m_stage = (m_stage + 1) % 4;
  endfunction

  // Hold the selected button(s) low for 'low' sampled cycles, release, let it settle.
  // A low run of at least DEB cycles is one press; clear wins over enter.
  task automatic key_run(input bit use_enter, input bit use_clr, input int low);
    @(negedge clk);
    if (use_enter) key_n = 1'b0;
    if (use_clr)   key_clr_n = 1'b0;
    repeat (low) @(negedge clk);
    key_n     = 1'b1;
    key_clr_n = 1'b1;
    repeat (SETTLE) @(negedge clk);
    if (low >= int'(DEB)) begin
      if (use_clr)        model_clear();
      else if (use_enter) model_enter();
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("after_reset");

    // Latency: A must still be old after edge 6 and new after edge 7.
    sw_data = 4'd3;
    @(negedge clk);
    key_n = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("lat_edge6_A", 32'(A), 32'd0);
    @(posedge clk);
    #1 check("lat_edge7_A", 32'(A), 32'd3);
    check("lat_edge7_led", 32'(led_stage), 32'b0010);
    @(negedge clk);
    key_n = 1'b1;
    repeat (SETTLE) @(negedge clk);
    model_enter();
    check_all("full_A");

    sw_data = 4'd9;
    key_run(1, 0, 6);
    check_all("full_B");
    sw_op = 3'd1;
    key_run(1, 0, 6);
    check_all("full_OP");
    key_run(1, 0, 6);
    check_all("full_SHOW_wrap");

    // Bounce: two short low runs separated by a short high gap.
    @(negedge clk);
    key_n = 1'b0; repeat (3) @(negedge clk);
    key_n = 1'b1; repeat (2) @(negedge clk);
    key_n = 1'b0; repeat (3) @(negedge clk);
    key_n = 1'b1; repeat (SETTLE) @(negedge clk);
    check_all("bounce_ignored");
    sw_data = 4'd12;
    key_run(1, 0, 10);
    check_all("bounce_then_press");

    // Long hold from S_A advances exactly once.
    key_run(0, 1, 6);
    check_all("clear_before_hold");
    sw_data = 4'd6;
    key_run(1, 0, 200);
    check_all("long_hold");

    // Clear and enter together in S_OP: clear wins.
    sw_data = 4'd10;
    key_run(1, 0, 6);
    check_all("to_S_OP");
    sw_op = 3'd5;
    key_run(1, 1, 10);
    check_all("clear_priority");

    // Switch changes without a press leave outputs untouched.
    sw_data = 4'd7;
    key_run(1, 0, 5);
    for (int v = 0; v < 16; v++) begin
      sw_data = 4'(v);
      sw_op   = 3'(v);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_all("switch_change");

    // Reset mid-sequence with A loaded and enter held through reset.
    key_run(0, 1, 6);
    sw_data = 4'd5;
    key_run(1, 0, 6);
    check_all("pre_reset_A5");
    @(negedge clk);
    key_n = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    key_n = 1'b1;
    repeat (SETTLE) @(negedge clk);
    check_all("no_pulse_after_reset");

    // Randomized mix of presses, glitches, clears and switch wiggles.
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 8));
      sw_data = 4'($urandom_range(0, 15));
      sw_op   = 3'($urandom_range(0, 7));
      case (sel)
        0, 1, 2, 3, 4: key_run(1, 0, int'($urandom_range(4, 20)));
        5:             key_run(1, 0, int'($urandom_range(1, 3)));
        6:             key_run(0, 1, int'($urandom_range(1, 10)));
        7:             key_run(1, 1, int'($urandom_range(4, 12)));
        default:       repeat (5) @(negedge clk);
      endcase
      check_all($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
